// File: rtl/rx_frame_deserializer_if.sv
// Bus between the UART RX deserializer and its surroundings: serial line,
// configuration, parity-checker handshake and received-frame outputs.
interface rx_frame_deserializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  rx_in;
  logic [PRESC_W-1:0]    prescale;
  logic                  par_en;
  logic                  par_chk_en;
  logic                  par_bit;
  logic [DATA_WIDTH-1:0] par_data;
  logic                  par_err;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  stop_err;
  logic                  par_err_o;

  modport master (
    input  rx_in, prescale, par_en, par_err,
    output par_chk_en, par_bit, par_data, p_data, data_valid, stop_err, par_err_o
  );

  modport slave (
    output rx_in, prescale, par_en, par_err,
    input  par_chk_en, par_bit, par_data, p_data, data_valid, stop_err, par_err_o
  );
endinterface

// File: rtl/rx_frame_deserializer.sv
// UART RX front end: oversampled 3-sample majority vote, start/data/parity/stop
// frame FSM, LSB-first deserializer and external parity-checker handshake.
module rx_frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  rx_frame_deserializer_if.master  bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [PRESC_W-1:0]    presc_r;
  logic [PRESC_W-1:0]    edge_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [1:0]            smp_r;
  logic                  vote_r;
  logic                  par_fail_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  par_chk_en_r;
  logic                  par_bit_r;
  logic                  data_valid_r;
  logic                  stop_err_r;
  logic                  par_err_o_r;

  logic [PRESC_W-1:0]    presc_s;
  logic [PRESC_W-1:0]    half_s;
  logic                  smp0_s;
  logic                  smp1_s;
  logic                  vote_ld_s;
  logic                  vote_cyc_s;
  logic                  last_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Legalise the requested prescale: clamp to 8..32, then force even.
  always_comb begin
    presc_s = PRESC_W'(8);
    if (bus.prescale < PRESC_W'(8)) begin
      presc_s = PRESC_W'(8);
    end else if (bus.prescale > PRESC_W'(32)) begin
      presc_s = PRESC_W'(32);
    end else begin
      presc_s = {bus.prescale[PRESC_W-1:1], 1'b0};
    end
  end

  // Position decodes within the current bit period.
  always_comb begin
    half_s     = {1'b0, presc_r[PRESC_W-1:1]};
    smp0_s     = (edge_cnt_r == (half_s - PRESC_W'(1)));
    smp1_s     = (edge_cnt_r == half_s);
    vote_ld_s  = (edge_cnt_r == (half_s + PRESC_W'(1)));
    vote_cyc_s = (edge_cnt_r == (half_s + PRESC_W'(2)));
    last_s     = (edge_cnt_r == (presc_r - PRESC_W'(1)));
  end

  // Frame FSM, sampling/vote pipeline, deserializer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      presc_r      <= PRESC_W'(8);
      edge_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      smp_r        <= 2'b00;
      vote_r       <= 1'b0;
      par_fail_r   <= 1'b0;
      shift_r      <= '0;
      p_data_r     <= '0;
      par_chk_en_r <= 1'b0;
      par_bit_r    <= 1'b0;
      data_valid_r <= 1'b0;
      stop_err_r   <= 1'b0;
      par_err_o_r  <= 1'b0;
    end else begin
      par_chk_en_r <= 1'b0;
      data_valid_r <= 1'b0;
      stop_err_r   <= 1'b0;
      par_err_o_r  <= 1'b0;

      // The third sample is taken straight from rx_in, so vote_r is valid in the vote cycle.
      if (state_r != IDLE) begin
        if (last_s) begin
          edge_cnt_r <= '0;
        end else begin
          edge_cnt_r <= edge_cnt_r + PRESC_W'(1);
        end
        if (smp0_s) begin
          smp_r[0] <= bus.rx_in;
        end
        if (smp1_s) begin
          smp_r[1] <= bus.rx_in;
        end
        if (vote_ld_s) begin
          vote_r <= maj3(smp_r[0], smp_r[1], bus.rx_in);
        end
      end

      case (state_r)
        IDLE: begin
          if (!bus.rx_in) begin
            state_r    <= START;
            edge_cnt_r <= '0;
            presc_r    <= presc_s;
            par_fail_r <= 1'b0;
          end
        end
        START: begin
          bit_cnt_r <= '0;
          if (last_s) begin
            state_r <= vote_r ? IDLE : DATA;
          end
        end
        DATA: begin
          if (vote_cyc_s) begin
            shift_r <= {vote_r, shift_r[DATA_WIDTH-1:1]};
          end
          if (last_s) begin
            if (bit_cnt_r == BIT_W'(DATA_WIDTH - 1)) begin
              state_r <= bus.par_en ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          // par_chk_en is high during the vote cycle; the checker answers in time for the bit end.
          if (vote_ld_s) begin
            par_bit_r    <= maj3(smp_r[0], smp_r[1], bus.rx_in);
            par_chk_en_r <= 1'b1;
          end
          if (last_s) begin
            par_fail_r <= bus.par_err;
            state_r    <= STOP;
          end
        end
        STOP: begin
          // Leave half a bit early so the next start edge is never missed.
          if (vote_cyc_s) begin
            state_r    <= IDLE;
            edge_cnt_r <= '0;
            if (!vote_r) begin
              stop_err_r <= 1'b1;
            end else if (par_fail_r) begin
              par_err_o_r <= 1'b1;
            end else begin
              p_data_r     <= shift_r;
              data_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          edge_cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.par_chk_en = par_chk_en_r;
  assign bus.par_bit    = par_bit_r;
  assign bus.par_data   = shift_r;
  assign bus.p_data     = p_data_r;
  assign bus.data_valid = data_valid_r;
  assign bus.stop_err   = stop_err_r;
  assign bus.par_err_o  = par_err_o_r;

endmodule
